data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Parametrised synchronous data memory for the processor datapath.
- Replaces the asynchronous load/store array with a clocked valid/ready request port and a registered response port.
- On reset, a hardware init sweep writes every location. Out-of-range accesses are flagged and counted.
- Sits between the execute stage's address/data outputs and the writeback mux.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, address width in bits.
- DEPTH, 100, number of words implemented. Must satisfy 1 <= DEPTH <= 2^ADDR_W.
- INIT_VAL, 0, value (DATA_W bits) written to every location during the init sweep.
- ERRCNT_W, 8, width of the out-of-range error counter.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, reset reset, synchronous, active-high.
- req_valid, input, 1, request present.
- req_ready, output, 1, block can accept a request this cycle.
- req_write, input, 1, 1 = store, 0 = load.
- req_addr, input, ADDR_W, word address.
- req_wdata, input, DATA_W, store data.
- rsp_valid, output, 1, one-cycle response strobe.
- rsp_data, output, DATA_W, load data or store echo.
- rsp_err, output, 1, address out of range; qualified by rsp_valid.
- init_busy, output, 1, init sweep in progress.
- err_count, output, ERRCNT_W, saturating count of out-of-range requests.

Behaviour:
- Reset (sampled at a rising edge with reset=1):
  - state <= INIT, init pointer <= 0.
  - rsp_valid <= 0, rsp_data <= 0, rsp_err <= 0, err_count <= 0.
  - Outputs during reset: req_ready = 0, init_busy = 1.
- FSM states: INIT, RUN.
- INIT:
  - Each edge with reset=0 writes INIT_VAL to mem[ptr] and increments ptr.
  - At the edge writing ptr = DEPTH-1, state <= RUN.
  - The sweep therefore takes exactly DEPTH edges after reset falls.
  - init_busy = 1 and req_ready = 0 throughout. Requests are ignored; no response is produced.
- RUN:
  - init_busy = 0 and req_ready = 1 (combinational from state).
  - No backpressure on responses.
- Accept: an edge with req_valid & req_ready. One request per cycle; back-to-back accepts are allowed.
- Latency: rsp_valid = 1 for exactly one cycle, on the cycle after the accept edge. Otherwise rsp_valid = 0.
- In-range load (req_addr < DEPTH): rsp_data = mem[req_addr] as it stood before the accept edge; rsp_err = 0.
- In-range store: mem[req_addr] <= req_wdata at the accept edge; rsp_data = req_wdata (echo); rsp_err = 0.
- Store then load to the same address on the next cycle returns the new data.
- Out-of-range (req_addr >= DEPTH), load or store:
  - No memory write; rsp_data = 0; rsp_err = 1.
  - err_count increments, saturating at 2^ERRCNT_W-1 (no wrap).
- rsp_data and rsp_err hold their last value while rsp_valid = 0.
- Reset mid-operation (in RUN or mid-sweep):
  - Any pending response is dropped: rsp_valid is 0 on the cycle after the reset edge.
  - The sweep restarts from address 0.
  - A request accepted on the same edge where reset=1 is discarded; reset has priority.
- Reset asserted for multiple cycles: state stays INIT with ptr = 0 and no memory writes.
- DEPTH = 2^ADDR_W: no address is out of range and err_count stays 0.
- Memory array is unreadable except through the response port. No combinational read path.

Test Plan:
1. Init sweep: hold reset=1 for 2 cycles, then release. Required: init_busy=1 and req_ready=0 for exactly 100 cycles, then req_ready=1. A load from addr 0 and from addr 99 each return 0x00 with rsp_err=0.
2. Store/load latency: store 0xA5 @ 0x10, then next cycle load @ 0x10. Required: rsp_valid on cycles +1 and +2; rsp_data 0xA5 (echo) then 0xA5 (load); rsp_err=0 on both.
3. Back-to-back stream: store addr i data i+0x40 for i=0..9 on consecutive cycles, then load 0..9 on consecutive cycles. Required: 10 consecutive load responses with data 0x40..0x49 and no bubbles.
4. Out-of-range: store 0xFF @ 100, then load @ 100, then load @ 255. Required: rsp_err=1 and rsp_data=0x00 on each; err_count=3. Addresses 0..99 are unchanged by the store.
5. Saturation: issue 260 out-of-range requests. Required: err_count stops at 255.
6. Reset mid-run: store 0x77 @ 5, assert reset on the cycle of a load @ 5, release. Required: no rsp_valid from the dropped load. A 100-cycle sweep follows, and a subsequent load @ 5 returns 0x00.

Source files
------------

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_ctrl
// Brief   : Clocked data memory with valid/ready request port, registered
//           response, reset-time init sweep and saturating error counter.
// Revision: 1.0
// ============================================================================
module data_mem_ctrl #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 100,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int                ERRCNT_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                init_busy,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int                c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [c_idx_w-1:0]    r_ptr;
  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic                  r_rsp_valid;
  logic [DATA_W-1:0]     r_rsp_data;
  logic                  r_rsp_err;
  logic [ERRCNT_W-1:0]   r_err_count;
  logic                  w_accept;
  logic                  w_in_range;
  logic [c_idx_w-1:0]    w_idx;

  // Reset masks the port immediately so a request on a reset edge is never taken.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    init_busy    = 1'b1;
    case (r_state)
      S_INIT: begin
        if (r_ptr == c_last) w_state_next = S_RUN;
      end
      S_RUN: begin
        req_ready = ~reset;
        init_busy = reset;
      end
      default: w_state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_state_next;
  end

  assign w_accept   = req_valid & req_ready;
  assign w_in_range = ({1'b0, req_addr} < c_depth);
  assign w_idx      = req_addr[c_idx_w-1:0];

  always_ff @(posedge clock) begin
    if (reset)                                  r_ptr <= '0;
    else if (r_state == S_INIT && r_ptr != c_last) r_ptr <= r_ptr + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (r_state == S_INIT)                          r_mem[r_ptr] <= INIT_VAL;
      else if (w_accept && req_write && w_in_range)  r_mem[w_idx] <= req_wdata;
    end
  end

  // Load data is read before the same-edge store lands, so it reflects prior contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        if (w_in_range) begin
          r_rsp_err  <= 1'b0;
          r_rsp_data <= req_write ? req_wdata : r_mem[w_idx];
        end else begin
          r_rsp_err  <= 1'b1;
          r_rsp_data <= '0;
          if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
        end
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_ctrl
// Brief   : Scoreboard bench for data_mem_ctrl with directed vectors.
// Revision: 1.0
// ============================================================================
module tb_data_mem_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       init_busy;
  logic [7:0] err_count;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t x;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  data_mem_ctrl #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(100), .INIT_VAL(8'h00), .ERRCNT_W(8)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .init_busy(init_busy), .err_count(err_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every response must match the oldest expectation and its due cycle.
  always @(negedge clock) begin
    if (rsp_valid === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: cyc=%0d data=%h err=%b, no response expected", cyc, rsp_data, rsp_err);
      end else begin
        x = sb.pop_front();
        if (rsp_data !== x.d || rsp_err !== x.e || cyc != x.cyc) begin
          n_fail++;
          $display("FAIL rsp: got data=%h err=%b cyc=%0d, expected data=%h err=%b cyc=%0d",
                   rsp_data, rsp_err, cyc, x.d, x.e, x.cyc);
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      n_vec++;
      n_fail++;
      x = sb.pop_front();
      $display("FAIL missing_rsp: rsp_valid=%b at cyc=%0d, expected data=%h err=%b", rsp_valid, cyc, x.d, x.e);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Inputs change at negedge; the request is accepted on the following posedge.
  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                       input logic [7:0] ed, input logic ee);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    sb.push_back('{d: ed, e: ee, cyc: cyc + 1});
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic sweep(input string nm);
    int n = 0;
    int ready_hi = 0;
    while (init_busy === 1'b1 && n < 300) begin
      n++;
      if (req_ready !== 1'b0) ready_hi++;
      @(negedge clock);
    end
    check({nm, "_busy_cycles"}, n, 100);
    check({nm, "_ready_during_init"}, ready_hi, 0);
    check({nm, "_ready_after"}, {31'd0, req_ready}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1);
  end

  initial begin
    // Init sweep after a two-cycle reset
    repeat (2) @(negedge clock);
    check("reset_ready", {31'd0, req_ready}, 0);
    check("reset_busy", {31'd0, init_busy}, 1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 0);
    check("reset_err_count", {24'd0, err_count}, 0);
    reset = 1'b0;
    sweep("init");
    issue(1'b0, 8'd0,  8'h00, 8'h00, 1'b0);
    issue(1'b0, 8'd99, 8'h00, 8'h00, 1'b0);
    idle(2);

    // Store then immediate load
    issue(1'b1, 8'h10, 8'hA5, 8'hA5, 1'b0);
    issue(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0);
    idle(2);

    // Back-to-back stream
    for (int i = 0; i < 10; i++) issue(1'b1, 8'(i), 8'(i + 8'h40), 8'(i + 8'h40), 1'b0);
    for (int i = 0; i < 10; i++) issue(1'b0, 8'(i), 8'h00, 8'(i + 8'h40), 1'b0);
    idle(2);

    // Out-of-range
    issue(1'b1, 8'd100, 8'hFF, 8'h00, 1'b1);
    issue(1'b0, 8'd100, 8'h00, 8'h00, 1'b1);
    issue(1'b0, 8'd255, 8'h00, 8'h00, 1'b1);
    idle(1);
    check("err_count_3", {24'd0, err_count}, 3);
    issue(1'b0, 8'd99, 8'h00, 8'h00, 1'b0);
    issue(1'b0, 8'd0,  8'h00, 8'h40, 1'b0);
    idle(2);

    // Saturation
    for (int i = 0; i < 260; i++) issue(i[0], 8'(100 + (i % 156)), 8'h5A, 8'h00, 1'b1);
    idle(1);
    check("err_count_sat", {24'd0, err_count}, 255);
    idle(1);

    // Reset during a load
    issue(1'b1, 8'd5, 8'h77, 8'h77, 1'b0);
    reset     = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'd5;
    @(negedge clock);
    check("reset_drop_rsp_valid", {31'd0, rsp_valid}, 0);
    check("reset_clears_err_count", {24'd0, err_count}, 0);
    reset     = 1'b0;
    req_valid = 1'b0;
    sweep("reinit");
    issue(1'b0, 8'd5, 8'h00, 8'h00, 1'b0);
    idle(3);

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
